// File: rtl/i2c_target_regs.sv
// I2C target with an internal register file.
// Oversamples SCL/SDA on clk, decodes START/STOP, ACKs its own address,
// writes received bytes into the register file and serves reads,
// including reads that follow a repeated START.
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         DEPTH      = 16,
    parameter int         DATA_WIDTH = 8,
    localparam int        AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  reg_wr_en,
    output logic [AW-1:0]         reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [AW-1:0]         host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    // Register indices are compared as 9-bit values so DEPTH = 256 works.
    localparam logic [8:0] DEPTH_LIMIT = 9'(DEPTH);

    state_t                state;
    logic                  scl_s1, scl_s2, scl_prev;
    logic                  sda_s1, sda_s2, sda_prev;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic [DATA_WIDTH-1:0] tx_reg;
    logic [3:0]            bit_cnt;
    logic                  phase;
    logic                  rw;
    logic [AW-1:0]         pointer;
    logic [DATA_WIDTH-1:0] regfile [DEPTH];

    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [DATA_WIDTH-1:0] rx_byte;

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
    assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

    // Byte as it stands once the current bit is shifted in.
    assign rx_byte = {shift_reg, sda_s2};

    assign host_rd_data = regfile[host_rd_addr];

    // Two-flop synchronizers plus a previous sample; reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= scl_in;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= sda_in;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    // Protocol state machine, register file and all registered outputs.
    // ACK slots use 'phase': first SCL fall pulls SDA, second fall releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sda_oe      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
            shift_reg   <= '0;
            tx_reg      <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            rw          <= 1'b0;
            pointer     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            reg_wr_en <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                phase  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte[DATA_WIDTH-2:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                rw      <= rx_byte[0];
                                phase   <= 1'b0;
                                state   <= (rx_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (rw) begin
                                    tx_reg  <= {regfile[pointer][DATA_WIDTH-2:0], 1'b0};
                                    sda_oe  <= ~regfile[pointer][DATA_WIDTH-1];
                                    bit_cnt <= 4'd1;
                                    state   <= S_RDATA;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    bit_cnt <= '0;
                                    state   <= S_REG;
                                end
                            end
                        end
                    end

                    S_REG: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte[DATA_WIDTH-2:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                phase   <= 1'b0;
                                if ({1'b0, rx_byte} < DEPTH_LIMIT) begin
                                    pointer <= rx_byte[AW-1:0];
                                    state   <= S_REG_ACK;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_REG_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                phase   <= 1'b0;
                                bit_cnt <= '0;
                                state   <= S_WDATA;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte[DATA_WIDTH-2:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt          <= '0;
                                phase            <= 1'b0;
                                reg_wr_en        <= 1'b1;
                                reg_wr_addr      <= pointer;
                                reg_wr_data      <= rx_byte;
                                regfile[pointer] <= rx_byte;
                                pointer          <= pointer + AW'(1);
                                state            <= S_WDATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt < 4'd8) begin
                                sda_oe  <= ~tx_reg[DATA_WIDTH-1];
                                tx_reg  <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                pointer <= pointer + AW'(1);
                                phase   <= 1'b0;
                                state   <= S_RDATA_ACK;
                            end
                        end
                    end

                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2) begin
                                state <= S_IGNORE;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            phase   <= 1'b0;
                            tx_reg  <= {regfile[pointer][DATA_WIDTH-2:0], 1'b0};
                            sda_oe  <= ~regfile[pointer][DATA_WIDTH-1];
                            bit_cnt <= 4'd1;
                            state   <= S_RDATA;
                        end
                    end

                    S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        state  <= S_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed testbench for i2c_target_regs: a bit-banged I2C master drives
// the bus and every scenario task checks its own results.
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [3:0] host_rd_addr;
    logic [7:0] host_rd_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         wr_count;
    logic [3:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    bit         oe_seen;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.SLAVE_ADDR(7'h42), .DEPTH(16), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl_m),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .busy         (busy)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Log every write pulse cycle and any SDA pull-down.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_count++;
            wr_addr_log.push_back(reg_wr_addr);
            wr_data_log.push_back(reg_wr_data);
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_count = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    // Sends a byte and returns the SDA level seen in the ACK slot.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            d[i] = sda_line; wait_q();
            scl_m = 1'b0; wait_q();
        end
        send_bit(nack);
        sda_m = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_rd_addr = 4'd3;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", reg_wr_en); end
        checks++; if (reg_wr_addr !== 4'd0 || reg_wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_bus: got %h/%h expected 0/00", reg_wr_addr, reg_wr_data); end
        checks++; if (host_rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_regfile: got %h expected 00", host_rd_data); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        clear_log();
        i2c_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_start: got %b expected 1", busy); end
        send_byte(8'h84, a0);
        send_byte(8'h03, a1);
        send_byte(8'hA5, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL single_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (wr_count !== 1) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected 1", wr_count); end
        if (wr_count == 1) begin
            checks++; if (wr_addr_log[0] !== 4'd3 || wr_data_log[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_wr: got %h/%h expected 3/a5", wr_addr_log[0], wr_data_log[0]); end
        end
        host_rd_addr = 4'd3; @(negedge clk);
        checks++; if (host_rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_host_rd: got %h expected a5", host_rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        clear_log();
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h86, a0);
        send_byte(8'h03, a1);
        send_byte(8'h77, a2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy); end
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL ignore_acks: got %b expected 111", {a0, a1, a2}); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("[TB] FAIL ignore_oe: got %b expected 0", oe_seen); end
        checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL ignore_pulses: got %0d expected 0", wr_count); end
        host_rd_addr = 4'd3; @(negedge clk);
        checks++; if (host_rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL ignore_keep: got %h expected a5", host_rd_data); end
    endtask

    task automatic test_burst_wrap();
        logic       a [5];
        logic [3:0] exp_a [3];
        logic [7:0] exp_d [3];
        exp_a = '{4'd14, 4'd15, 4'd0};
        exp_d = '{8'h11, 8'h22, 8'h33};
        clear_log();
        i2c_start();
        send_byte(8'h84, a[0]);
        send_byte(8'h0E, a[1]);
        send_byte(8'h11, a[2]);
        send_byte(8'h22, a[3]);
        send_byte(8'h33, a[4]);
        i2c_stop();
        checks++; if ({a[0], a[1], a[2], a[3], a[4]} !== 5'b00000) begin errors++; $display("[TB] FAIL burst_acks: got %b expected 00000", {a[0], a[1], a[2], a[3], a[4]}); end
        checks++; if (wr_count !== 3) begin errors++; $display("[TB] FAIL burst_pulses: got %0d expected 3", wr_count); end
        if (wr_count == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_log[i] !== exp_a[i] || wr_data_log[i] !== exp_d[i]) begin
                    errors++;
                    $display("[TB] FAIL burst_wr%0d: got %h/%h expected %h/%h", i, wr_addr_log[i], wr_data_log[i], exp_a[i], exp_d[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            host_rd_addr = exp_a[i]; @(negedge clk);
            checks++; if (host_rd_data !== exp_d[i]) begin errors++; $display("[TB] FAIL burst_host_rd%0d: got %h expected %h", i, host_rd_data, exp_d[i]); end
        end
    endtask

    task automatic test_bad_reg();
        logic a0, a1, a2;
        clear_log();
        i2c_start();
        send_byte(8'h84, a0);
        oe_seen = 1'b0;
        send_byte(8'h20, a1);
        send_byte(8'h99, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b011) begin errors++; $display("[TB] FAIL badreg_acks: got %b expected 011", {a0, a1, a2}); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("[TB] FAIL badreg_oe: got %b expected 0", oe_seen); end
        checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL badreg_pulses: got %0d expected 0", wr_count); end
        host_rd_addr = 4'd0; @(negedge clk);
        checks++; if (host_rd_data !== 8'h33) begin errors++; $display("[TB] FAIL badreg_keep: got %h expected 33", host_rd_data); end
    endtask

    task automatic test_read();
        logic       a [6];
        logic [7:0] d0, d1;
        clear_log();
        i2c_start();
        send_byte(8'h84, a[0]);
        send_byte(8'h05, a[1]);
        send_byte(8'h5A, a[2]);
        send_byte(8'h3C, a[3]);
        i2c_stop();
        checks++; if (wr_count !== 2) begin errors++; $display("[TB] FAIL read_setup_pulses: got %0d expected 2", wr_count); end
        clear_log();
        i2c_start();
        send_byte(8'h84, a[4]);
        send_byte(8'h05, a[5]);
        i2c_start();
        send_byte(8'h85, a[0]);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        oe_seen = 1'b0;
        wait_q();
        checks++; if ({a[0], a[1], a[2], a[3], a[4], a[5]} !== 6'b000000) begin errors++; $display("[TB] FAIL read_acks: got %b expected 000000", {a[0], a[1], a[2], a[3], a[4], a[5]}); end
        checks++; if (d0 !== 8'h5A) begin errors++; $display("[TB] FAIL read_byte0: got %h expected 5a", d0); end
        checks++; if (d1 !== 8'h3C) begin errors++; $display("[TB] FAIL read_byte1: got %h expected 3c", d1); end
        checks++; if (oe_seen !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL read_release: got %b expected 0", oe_seen | sda_oe); end
        i2c_stop();
        checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL read_pulses: got %0d expected 0", wr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic a0, a1, a2;
        clear_log();
        i2c_start();
        send_byte(8'h84, a0);
        send_byte(8'h07, a1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1; @(negedge clk);
        rst = 1'b0; @(negedge clk);
        checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_reset: got oe=%b busy=%b expected 0/0", sda_oe, busy); end
        wait_q();
        scl_m = 1'b0; wait_q();
        i2c_stop();
        checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL mid_pulses: got %0d expected 0", wr_count); end
        host_rd_addr = 4'd14; @(negedge clk);
        checks++; if (host_rd_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_regfile_cleared: got %h expected 00", host_rd_data); end
        i2c_start();
        send_byte(8'h84, a0);
        send_byte(8'h07, a1);
        send_byte(8'hC3, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL mid_next_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (wr_count !== 1) begin errors++; $display("[TB] FAIL mid_next_pulses: got %0d expected 1", wr_count); end
        host_rd_addr = 4'd7; @(negedge clk);
        checks++; if (host_rd_data !== 8'hC3) begin errors++; $display("[TB] FAIL mid_next_rd: got %h expected c3", host_rd_data); end
    endtask

    // Scenario sequence.
    initial begin
        wr_count = 0;
        oe_seen  = 1'b0;
        test_reset();
        test_single_write();
        test_wrong_addr();
        test_burst_wrap();
        test_bad_reg();
        test_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
